// File: rtl/pi_sample_gen.sv
// Monte-Carlo pi sample generator: LFSR points tested against the unit quarter-circle.
// Build macro SUM_PIPE_REG_EN registers the 33-bit sum (latency 3 instead of 2).
module pi_sample_gen #(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] num_samples,
  input  logic        hold,
  output logic        enable,
  output logic        dout_valid,
  output logic        dout,
  output logic        busy
);

  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] remaining;
  logic [31:0] lfsr;
  logic [31:0] lfsr_cur;
  logic [31:0] lfsr_adv;
  logic        accept;
  logic        issue;
  logic        s1_vld;
  logic [15:0] s1_x;
  logic [15:0] s1_y;
  logic        s2_vld;
  logic [31:0] s2_xx;
  logic [31:0] s2_yy;
  logic        sum_hit;
  logic        out_vld;
  logic        out_hit;
  logic        upstream_vld;
  logic        last_out;

  assign accept   = (state == IDLE) && start && (num_samples != 32'd0);
  assign issue    = (state == RUN) && !hold;
  assign lfsr_cur = (lfsr == 32'd0) ? 32'd1 : lfsr;
  assign lfsr_adv = {1'b0, lfsr_cur[31:1]} ^ (lfsr_cur[0] ? TAPS : 32'd0);
  // Hit iff the 33-bit sum has no carry out of bit 31.
  assign sum_hit  = ({1'b0, s2_xx} + {1'b0, s2_yy}) < 33'h1_0000_0000;

`ifdef SUM_PIPE_REG_EN
  logic s3_vld;
  logic s3_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_vld <= 1'b0;
      s3_hit <= 1'b0;
    end else begin
      s3_vld <= s2_vld;
      s3_hit <= sum_hit;
    end
  end

  assign out_vld      = s3_vld;
  assign out_hit      = s3_hit;
  assign upstream_vld = s1_vld | s2_vld;
`else
  assign out_vld      = s2_vld;
  assign out_hit      = sum_hit;
  assign upstream_vld = s1_vld;
`endif

  // No issue happens in DRAIN, so an output with nothing behind it is the last one.
  assign last_out = out_vld && !upstream_vld;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (issue && remaining == 32'd1) state_next = DRAIN;
      DRAIN:   if (last_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= 32'd0;
      lfsr      <= SEED;
      s1_vld    <= 1'b0;
      s1_x      <= 16'd0;
      s1_y      <= 16'd0;
      s2_vld    <= 1'b0;
      s2_xx     <= 32'd0;
      s2_yy     <= 32'd0;
    end else begin
      if (accept)     remaining <= num_samples;
      else if (issue) remaining <= remaining - 32'd1;

      if (issue)               lfsr <= lfsr_adv;
      else if (lfsr == 32'd0)  lfsr <= 32'd1;

      s1_vld <= issue;
      if (issue) begin
        s1_x <= lfsr_cur[31:16];
        s1_y <= lfsr_cur[15:0];
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_xx <= {16'd0, s1_x} * {16'd0, s1_x};
        s2_yy <= {16'd0, s1_y} * {16'd0, s1_y};
      end
    end
  end

  assign enable     = (state == RUN) || (state == DRAIN);
  assign busy       = (state != IDLE);
  assign dout_valid = out_vld;
  assign dout       = out_vld & out_hit;

endmodule

// File: doc/pi_sample_gen.md
PI_SAMPLE_GEN -- requirements
Module: pi_sample_gen

Interface
REQ-001 SHALL have parameter SEED, default 32'hACE1_2468, initial LFSR value; SHALL be nonzero.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  pulse that begins a run; sampled only in IDLE.
REQ-005 SHALL have port num_samples  input  32  samples per run; latched on accepted start.
REQ-006 SHALL have port hold  input  1  when high, suppresses sample issue; pipeline keeps draining.
REQ-007 SHALL have port enable  output  1  run window; drives the downstream accumulator enable.
REQ-008 SHALL have port dout_valid  output  1  one sample result present this cycle.
REQ-009 SHALL have port dout  output  1  1 = point inside unit quarter-circle (hit), 0 = miss.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN on start with num_samples != 0; start with num_samples == 0 ignored.
REQ-012 SHALL ignore start while in RUN or DRAIN.
REQ-013 SHALL keep a 32-bit remaining counter, loaded from num_samples; in RUN each cycle with hold=0 issues one sample and decrements it.
REQ-014 SHALL move RUN->DRAIN in the cycle the last sample issues (counter 1->0).
REQ-015 SHALL move DRAIN->IDLE in the cycle after the last dout_valid; enable SHALL fall on that transition.
REQ-016 SHALL assert enable exactly while state is RUN or DRAIN.
REQ-017 SHALL use a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (tap mask 32'h8020_0003), advanced once per issued sample only.
REQ-018 SHALL take sample x = LFSR[31:16], y = LFSR[15:0] from the value before advance.
REQ-019 SHALL compute x*x + y*y unsigned at 33 bits; dout = ~sum[32] (hit iff sum < 2^32).
REQ-020 SHALL register stage 1 (x,y) and stage 2 (squares); base latency issue->dout_valid = 2 cycles.
REQ-021 SHALL never assert dout_valid in the first enable-high cycle, so the accumulator clear is not lost.
REQ-022 SHALL retain LFSR state across runs; it is not reseeded at start.
REQ-023 SHALL force the LFSR to 32'h1 if it ever reads all-zero.
REQ-024 SHALL produce exactly num_samples dout_valid pulses per run, in issue order, irrespective of hold pattern.
REQ-025 SHALL drive dout = 0 whenever dout_valid = 0.

Reset
REQ-026 SHALL, on reset (wins over all inputs, including mid-run), set state IDLE, enable=0, dout_valid=0, dout=0, busy=0, counter=0, LFSR=SEED, and flush all pipeline valids.
REQ-027 SHALL not emit dout_valid for samples in flight at reset.

Configuration
REQ-028 SHALL honour macro SUM_PIPE_REG_EN: when defined, an extra register follows the 33-bit adder and latency = 3 cycles.
REQ-029 SHALL, without SUM_PIPE_REG_EN, compare the sum combinationally from the squares register, latency = 2 cycles; sequencing per REQ-015 uses the active latency.

Verification
REQ-030 SHALL cover: SEED=32'h8000_8000, num_samples=1, start at cycle 0 -> enable high cycles 1..3, single dout_valid at cycle 3 with dout=1 (sum=0x8000_0000); with SUM_PIPE_REG_EN, enable 1..4, valid at 4.
REQ-031 SHALL cover: SEED=32'hFFFF_FFFF, num_samples=1 -> one dout_valid with dout=0 (sum=0x1_FFFC_0002).
REQ-032 SHALL cover: num_samples=1000, hold random 30% -> exactly 1000 dout_valid; hit bits match a golden LFSR model; downstream accumulator result equals model hit count; accumulator done=1 after enable falls.
REQ-033 SHALL cover: num_samples=0 start, and start pulsed during RUN -> no state change, no extra samples.
REQ-034 SHALL cover: reset asserted in RUN with 3 samples in flight -> next cycle all outputs 0, no further dout_valid; a following run starts from LFSR=SEED.
REQ-035 SHALL cover: two back-to-back runs of 4 -> second run samples continue the LFSR sequence (no reseed).
